// File: rtl/net_cmd_dispatcher.sv
// Network command dispatcher: buffers {op, addr, data} packets in a FIFO and
// issues imem/register/PC write strobes to the core, including the IDLE wake handshake.
package net_cmd_pkg;
   typedef enum logic [1:0] {RUN = 2'd0, IDLE = 2'd1, ERR = 2'd2} state_e;

   localparam logic [2:0] OP_NOP        = 3'd0;
   localparam logic [2:0] OP_IMEM_WRITE = 3'd1;
   localparam logic [2:0] OP_REG_WRITE  = 3'd2;
   localparam logic [2:0] OP_PC_WRITE   = 3'd3;
   localparam logic [2:0] OP_PC_WAKE    = 3'd4;
endpackage

module net_cmd_dispatcher
   import net_cmd_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 10,
   parameter int PC_W       = 10,
   parameter int DATA_W     = 32
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            net_valid_i,
   output logic                            net_ready_o,
   input  logic [2:0]                      net_op_i,
   input  logic [ADDR_W-1:0]               net_addr_i,
   input  logic [DATA_W-1:0]               net_data_i,
   input  state_e                          state_i,
   input  logic                            stall_i,
   output logic                            imem_we_o,
   output logic [ADDR_W-1:0]               imem_addr_o,
   output logic [DATA_W-1:0]               imem_data_o,
   output logic                            reg_we_o,
   output logic [4:0]                      reg_addr_o,
   output logic [DATA_W-1:0]               reg_data_o,
   output logic                            net_PC_write_cmd_o,
   output logic [PC_W-1:0]                 net_PC_o,
   output logic                            net_PC_write_cmd_IDLE_o,
   output logic                            illegal_op_o,
   output logic                            wake_dropped_o,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {D_EMPTY, D_ISSUE, D_WAIT_IDLE} disp_state_e;

   disp_state_e state, next_state;

   logic [2:0]        op_mem   [FIFO_DEPTH];
   logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
   logic [DATA_W-1:0] data_mem [FIFO_DEPTH];

   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;

   logic              push, pop;
   logic              do_imem, do_reg, do_pc, do_wake, do_drop;
   logic [2:0]        head_op;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;

   assign net_ready_o  = (count != CNT_W'(FIFO_DEPTH));
   assign push         = net_valid_i & net_ready_o;
   assign fifo_count_o = count;
   assign head_op      = op_mem[rd_ptr];
   assign head_addr    = addr_mem[rd_ptr];
   assign head_data    = data_mem[rd_ptr];

   // Payload storage needs no reset; occupancy is tracked by pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         op_mem[wr_ptr]   <= net_op_i;
         addr_mem[wr_ptr] <= net_addr_i;
         data_mem[wr_ptr] <= net_data_i;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         state  <= D_EMPTY;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      pop        = 1'b0;
      do_imem    = 1'b0;
      do_reg     = 1'b0;
      do_pc      = 1'b0;
      do_wake    = 1'b0;
      do_drop    = 1'b0;
      case (state)
         D_EMPTY: begin
            if (count != '0) next_state = D_ISSUE;
         end
         D_ISSUE: begin
            case (head_op)
               OP_IMEM_WRITE: begin
                  pop     = ~stall_i;
                  do_imem = ~stall_i;
               end
               OP_REG_WRITE: begin
                  pop    = ~stall_i;
                  do_reg = ~stall_i;
               end
               OP_PC_WRITE: begin
                  pop   = ~stall_i;
                  do_pc = ~stall_i;
               end
               OP_PC_WAKE: next_state = D_WAIT_IDLE;
               // NOP and illegal ops are discarded regardless of stall.
               default: pop = 1'b1;
            endcase
         end
         D_WAIT_IDLE: begin
            if (state_i == IDLE && !stall_i) begin
               pop     = 1'b1;
               do_pc   = 1'b1;
               do_wake = 1'b1;
            end else if (state_i == ERR) begin
               pop     = 1'b1;
               do_drop = 1'b1;
            end
         end
         default: next_state = D_EMPTY;
      endcase
      // Entries remaining after this pop include any packet pushed on the same edge.
      if (pop) next_state = (count > CNT_W'(1) || push) ? D_ISSUE : D_EMPTY;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         imem_we_o               <= 1'b0;
         imem_addr_o             <= '0;
         imem_data_o             <= '0;
         reg_we_o                <= 1'b0;
         reg_addr_o              <= '0;
         reg_data_o              <= '0;
         net_PC_write_cmd_o      <= 1'b0;
         net_PC_o                <= '0;
         net_PC_write_cmd_IDLE_o <= 1'b0;
         illegal_op_o            <= 1'b0;
         wake_dropped_o          <= 1'b0;
      end else begin
         imem_we_o               <= do_imem;
         reg_we_o                <= do_reg;
         net_PC_write_cmd_o      <= do_pc;
         net_PC_write_cmd_IDLE_o <= do_wake;
         if (do_imem) begin
            imem_addr_o <= head_addr;
            imem_data_o <= head_data;
         end
         if (do_reg) begin
            reg_addr_o <= head_addr[4:0];
            reg_data_o <= head_data;
         end
         if (do_pc) net_PC_o <= head_addr[PC_W-1:0];
         if (push && net_op_i > OP_PC_WAKE) illegal_op_o <= 1'b1;
         if (do_drop) wake_dropped_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_net_cmd_dispatcher.sv
// Directed testbench for net_cmd_dispatcher: each task drives one scenario
// and compares outputs against hand-derived cycle-by-cycle expectations.
module tb_net_cmd_dispatcher;
   import net_cmd_pkg::*;

   logic        clk;
   logic        reset;
   logic        net_valid_i;
   logic        net_ready_o;
   logic [2:0]  net_op_i;
   logic [9:0]  net_addr_i;
   logic [31:0] net_data_i;
   state_e      state_i;
   logic        stall_i;
   logic        imem_we_o;
   logic [9:0]  imem_addr_o;
   logic [31:0] imem_data_o;
   logic        reg_we_o;
   logic [4:0]  reg_addr_o;
   logic [31:0] reg_data_o;
   logic        net_PC_write_cmd_o;
   logic [9:0]  net_PC_o;
   logic        net_PC_write_cmd_IDLE_o;
   logic        illegal_op_o;
   logic        wake_dropped_o;
   logic [2:0]  fifo_count_o;

   int compared   = 0;
   int mismatched = 0;

   net_cmd_dispatcher #(
      .FIFO_DEPTH(4), .ADDR_W(10), .PC_W(10), .DATA_W(32)
   ) dut (
      .clk(clk), .reset(reset),
      .net_valid_i(net_valid_i), .net_ready_o(net_ready_o),
      .net_op_i(net_op_i), .net_addr_i(net_addr_i), .net_data_i(net_data_i),
      .state_i(state_i), .stall_i(stall_i),
      .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o),
      .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o), .reg_data_o(reg_data_o),
      .net_PC_write_cmd_o(net_PC_write_cmd_o), .net_PC_o(net_PC_o),
      .net_PC_write_cmd_IDLE_o(net_PC_write_cmd_IDLE_o),
      .illegal_op_o(illegal_op_o), .wake_dropped_o(wake_dropped_o),
      .fifo_count_o(fifo_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge, where outputs are sampled and inputs changed.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic valid, input logic [2:0] op, input logic [9:0] addr, input logic [31:0] data);
      net_valid_i = valid;
      net_op_i    = op;
      net_addr_i  = addr;
      net_data_i  = data;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b0, 3'd0, '0, '0);
      state_i = RUN;
      stall_i = 1'b0;
      tick();
      tick();
      compared++; if (imem_we_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_imem_we got %b want 0", imem_we_o); end
      compared++; if (reg_we_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_reg_we got %b want 0", reg_we_o); end
      compared++; if (net_PC_write_cmd_o !== 1'b0 || net_PC_write_cmd_IDLE_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_pc_strobes got %b%b want 00", net_PC_write_cmd_o, net_PC_write_cmd_IDLE_o); end
      compared++; if (imem_addr_o !== 10'h0 || imem_data_o !== 32'h0 || reg_addr_o !== 5'h0 || reg_data_o !== 32'h0 || net_PC_o !== 10'h0) begin mismatched++; $display("[TB] FAIL reset_addr_data got %h %h %h %h %h want all 0", imem_addr_o, imem_data_o, reg_addr_o, reg_data_o, net_PC_o); end
      compared++; if (illegal_op_o !== 1'b0 || wake_dropped_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_sticky got %b%b want 00", illegal_op_o, wake_dropped_o); end
      compared++; if (fifo_count_o !== 3'd0 || net_ready_o !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_fifo got count %0d ready %b want 0 1", fifo_count_o, net_ready_o); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_imem_write();
      drive(1'b1, OP_IMEM_WRITE, 10'h012, 32'hDEADBEEF);
      tick();
      drive(1'b0, 3'd0, '0, '0);
      compared++; if (fifo_count_o !== 3'd1) begin mismatched++; $display("[TB] FAIL imem_count_after_push got %0d want 1", fifo_count_o); end
      tick();
      compared++; if (imem_we_o !== 1'b0) begin mismatched++; $display("[TB] FAIL imem_we_early got %b want 0", imem_we_o); end
      tick();
      compared++; if (imem_we_o !== 1'b1) begin mismatched++; $display("[TB] FAIL imem_we_strobe got %b want 1", imem_we_o); end
      compared++; if (imem_addr_o !== 10'h012 || imem_data_o !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL imem_payload got %h/%h want 012/deadbeef", imem_addr_o, imem_data_o); end
      compared++; if (fifo_count_o !== 3'd0) begin mismatched++; $display("[TB] FAIL imem_count_drained got %0d want 0", fifo_count_o); end
      tick();
      compared++; if (imem_we_o !== 1'b0 || imem_addr_o !== 10'h012) begin mismatched++; $display("[TB] FAIL imem_one_cycle_hold got we %b addr %h want 0 012", imem_we_o, imem_addr_o); end
   endtask

   task automatic test_back_to_back();
      stall_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, OP_REG_WRITE, 10'(i + 1), 32'h100 + 32'(i));
         compared++; if (net_ready_o !== (i < 4)) begin mismatched++; $display("[TB] FAIL full_ready_%0d got %b want %b", i, net_ready_o, (i < 4)); end
         tick();
      end
      compared++; if (fifo_count_o !== 3'd4 || reg_we_o !== 1'b0) begin mismatched++; $display("[TB] FAIL full_count_stalled got %0d we %b want 4 0", fifo_count_o, reg_we_o); end
      stall_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (k == 1) drive(1'b0, 3'd0, '0, '0);
         compared++; if (reg_we_o !== 1'b1 || reg_addr_o !== 5'(k + 1) || reg_data_o !== 32'h100 + 32'(k)) begin mismatched++; $display("[TB] FAIL b2b_pulse_%0d got we %b addr %h data %h want 1 %h %h", k, reg_we_o, reg_addr_o, reg_data_o, k + 1, 32'h100 + 32'(k)); end
         if (k == 0) begin
            compared++; if (net_ready_o !== 1'b1 || fifo_count_o !== 3'd3) begin mismatched++; $display("[TB] FAIL slot_freed got ready %b count %0d want 1 3", net_ready_o, fifo_count_o); end
         end
         if (k == 1) begin
            compared++; if (fifo_count_o !== 3'd3) begin mismatched++; $display("[TB] FAIL fifth_accepted got count %0d want 3", fifo_count_o); end
         end
      end
      tick();
      compared++; if (reg_we_o !== 1'b0 || fifo_count_o !== 3'd0) begin mismatched++; $display("[TB] FAIL b2b_done got we %b count %0d want 0 0", reg_we_o, fifo_count_o); end
   endtask

   task automatic test_wake_run_idle();
      int early;
      early = 0;
      state_i = RUN;
      drive(1'b1, OP_PC_WAKE, 10'h040, 32'h0);
      tick();
      drive(1'b0, 3'd0, '0, '0);
      for (int c = 0; c < 10; c++) begin
         tick();
         if (net_PC_write_cmd_o !== 1'b0 || net_PC_write_cmd_IDLE_o !== 1'b0) early++;
      end
      compared++; if (early !== 0) begin mismatched++; $display("[TB] FAIL wake_during_run got %0d strobe cycles want 0", early); end
      state_i = IDLE;
      tick();
      compared++; if (net_PC_write_cmd_o !== 1'b1 || net_PC_write_cmd_IDLE_o !== 1'b1 || net_PC_o !== 10'h040) begin mismatched++; $display("[TB] FAIL wake_strobe got %b%b pc %h want 11 040", net_PC_write_cmd_o, net_PC_write_cmd_IDLE_o, net_PC_o); end
      tick();
      compared++; if (net_PC_write_cmd_o !== 1'b0 || net_PC_write_cmd_IDLE_o !== 1'b0 || fifo_count_o !== 3'd0) begin mismatched++; $display("[TB] FAIL wake_one_cycle got %b%b count %0d want 00 0", net_PC_write_cmd_o, net_PC_write_cmd_IDLE_o, fifo_count_o); end
      state_i = RUN;
   endtask

   task automatic test_wake_err();
      state_i = ERR;
      drive(1'b1, OP_PC_WAKE, 10'h055, 32'h0);
      tick();
      drive(1'b1, OP_REG_WRITE, 10'h007, 32'hCAFE0007);
      tick();
      drive(1'b0, 3'd0, '0, '0);
      tick();
      tick();
      compared++; if (wake_dropped_o !== 1'b1 || net_PC_write_cmd_o !== 1'b0) begin mismatched++; $display("[TB] FAIL err_drop got dropped %b pc_cmd %b want 1 0", wake_dropped_o, net_PC_write_cmd_o); end
      tick();
      compared++; if (reg_we_o !== 1'b1 || reg_addr_o !== 5'h07 || reg_data_o !== 32'hCAFE0007) begin mismatched++; $display("[TB] FAIL err_then_reg got we %b addr %h data %h want 1 07 cafe0007", reg_we_o, reg_addr_o, reg_data_o); end
      state_i = RUN;
      tick();
      compared++; if (wake_dropped_o !== 1'b1 || fifo_count_o !== 3'd0) begin mismatched++; $display("[TB] FAIL err_sticky got dropped %b count %0d want 1 0", wake_dropped_o, fifo_count_o); end
   endtask

   task automatic test_illegal_nop();
      stall_i = 1'b1;
      drive(1'b1, 3'd6, 10'h003, 32'h12345678);
      tick();
      compared++; if (illegal_op_o !== 1'b1) begin mismatched++; $display("[TB] FAIL illegal_flag got %b want 1", illegal_op_o); end
      drive(1'b1, OP_NOP, 10'h000, 32'h0);
      tick();
      drive(1'b1, OP_PC_WRITE, 10'h3FF, 32'h0);
      tick();
      drive(1'b0, 3'd0, '0, '0);
      tick();
      tick();
      compared++; if (fifo_count_o !== 3'd1 || net_PC_write_cmd_o !== 1'b0 || imem_we_o !== 1'b0 || reg_we_o !== 1'b0) begin mismatched++; $display("[TB] FAIL discard_under_stall got count %0d strobes %b%b%b want 1 000", fifo_count_o, imem_we_o, reg_we_o, net_PC_write_cmd_o); end
      stall_i = 1'b0;
      tick();
      compared++; if (net_PC_write_cmd_o !== 1'b1 || net_PC_o !== 10'h3FF || net_PC_write_cmd_IDLE_o !== 1'b0) begin mismatched++; $display("[TB] FAIL pc_write got cmd %b pc %h idle %b want 1 3ff 0", net_PC_write_cmd_o, net_PC_o, net_PC_write_cmd_IDLE_o); end
      tick();
      compared++; if (net_PC_write_cmd_o !== 1'b0 || fifo_count_o !== 3'd0 || illegal_op_o !== 1'b1) begin mismatched++; $display("[TB] FAIL pc_write_done got cmd %b count %0d illegal %b want 0 0 1", net_PC_write_cmd_o, fifo_count_o, illegal_op_o); end
   endtask

   task automatic test_reset_mid();
      int strobes;
      strobes = 0;
      state_i = RUN;
      drive(1'b1, OP_PC_WAKE, 10'h080, 32'h0);
      tick();
      drive(1'b1, OP_REG_WRITE, 10'h011, 32'hAAAA0001);
      tick();
      drive(1'b1, OP_REG_WRITE, 10'h012, 32'hAAAA0002);
      tick();
      drive(1'b0, 3'd0, '0, '0);
      tick();
      compared++; if (fifo_count_o !== 3'd3) begin mismatched++; $display("[TB] FAIL mid_queued got %0d want 3", fifo_count_o); end
      reset = 1'b1;
      #1;
      compared++; if (fifo_count_o !== 3'd0 || net_ready_o !== 1'b1 || illegal_op_o !== 1'b0 || wake_dropped_o !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_async_reset got count %0d ready %b flags %b%b want 0 1 00", fifo_count_o, net_ready_o, illegal_op_o, wake_dropped_o); end
      compared++; if (reg_addr_o !== 5'h0 || reg_data_o !== 32'h0 || net_PC_o !== 10'h0 || imem_addr_o !== 10'h0) begin mismatched++; $display("[TB] FAIL mid_reset_outputs got %h %h %h %h want 0", reg_addr_o, reg_data_o, net_PC_o, imem_addr_o); end
      state_i = IDLE;
      tick();
      reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (imem_we_o || reg_we_o || net_PC_write_cmd_o || net_PC_write_cmd_IDLE_o) strobes++;
      end
      compared++; if (strobes !== 0 || fifo_count_o !== 3'd0) begin mismatched++; $display("[TB] FAIL mid_no_strobe_after got %0d strobes count %0d want 0 0", strobes, fifo_count_o); end
   endtask

   initial begin
      test_reset();
      test_imem_write();
      test_back_to_back();
      test_wake_run_idle();
      test_wake_err();
      test_illegal_nop();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
